// File: rtl/serial_add8_if.sv
// Operand/result bundle for the bit-serial 8-bit adder.
// The master issues A/B/Cin with a start pulse; the slave returns S/Cout/V with status.
interface serial_add8_if;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] S;
  logic       Cout;
  logic       V;
  logic       busy;
  logic       done;

  modport master (
    output start, A, B, Cin,
    input  S, Cout, V, busy, done
  );

  modport slave (
    input  start, A, B, Cin,
    output S, Cout, V, busy, done
  );
endinterface

// File: rtl/serial_add8.sv
// Bit-serial 8-bit adder: one full-adder cell plus a carry flop, resolving LSB first.
// Results are published only at the RUN->DONE edge, so S/Cout/V never show partial sums.
module serial_add8 (
  input  logic         clk,
  input  logic         rst,
  serial_add8_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_a_sh;
  logic [7:0] r_b_sh;
  logic [7:0] r_s_sh;
  logic       r_carry;
  logic       r_c7;
  logic [2:0] r_cnt;
  logic [7:0] r_s;
  logic       r_cout;
  logic       r_v;
  logic       r_busy;
  logic       r_done;
  logic [1:0] w_fa;
  logic       w_sum_bit;
  logic       w_carry_out;

  // Single full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (c & (a ^ b));
    return {co, s};
  endfunction

  assign w_fa        = full_add(r_a_sh[0], r_b_sh[0], r_carry);
  assign w_sum_bit   = w_fa[0];
  assign w_carry_out = w_fa[1];

  // Next-state logic; start only matters in IDLE and DONE always falls back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == 3'd7) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, serial datapath and registered result/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a_sh  <= 8'd0;
      r_b_sh  <= 8'd0;
      r_s_sh  <= 8'd0;
      r_carry <= 1'b0;
      r_c7    <= 1'b0;
      r_cnt   <= 3'd0;
      r_s     <= 8'd0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.A;
            r_b_sh  <= bus.B;
            r_carry <= bus.Cin;
            r_cnt   <= 3'd0;
          end
        end
        ST_RUN: begin
          r_s_sh  <= {w_sum_bit, r_s_sh[7:1]};
          r_a_sh  <= {1'b0, r_a_sh[7:1]};
          r_b_sh  <= {1'b0, r_b_sh[7:1]};
          r_carry <= w_carry_out;
          r_cnt   <= r_cnt + 3'd1;
          // Carry out of bit 6 is the carry into bit 7, needed for signed overflow.
          if (r_cnt == 3'd6) begin
            r_c7 <= w_carry_out;
          end
          if (r_cnt == 3'd7) begin
            r_s    <= {w_sum_bit, r_s_sh[7:1]};
            r_cout <= w_carry_out;
            r_v    <= r_c7 ^ w_carry_out;
          end
        end
        ST_DONE: begin
          r_cnt <= 3'd0;
        end
        default: begin
          r_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign bus.S    = r_s;
  assign bus.Cout = r_cout;
  assign bus.V    = r_v;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_serial_add8.sv
// Directed scoreboard bench for serial_add8: the driver queues expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_add8;

  logic clk;
  logic rst;
  serial_add8_if bus ();

  serial_add8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         n_done = 0;
  logic [7:0] held_s = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      logic [9:0] e;
      n_done++;
      check("busy_done_excl", {31'd0, bus.busy}, 32'd0);
      check("done_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result_S", {24'd0, bus.S}, {24'd0, e[9:2]});
        check("result_Cout", {31'd0, bus.Cout}, {31'd0, e[1]});
        check("result_V", {31'd0, bus.V}, {31'd0, e[0]});
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input logic ev,
                        input bit perturb);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    exp_q.push_back({es, ec, ev});
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (perturb) begin
        bus.A     = 8'(c * 37);
        bus.B     = ~bus.A;
        bus.Cin   = 1'(c);
        bus.start = (c == 4);
        if (c == 4) begin
          bus.A = 8'hFF;
          bus.B = 8'hFF;
        end
      end
      @(negedge clk);
      check("busy_run", {31'd0, bus.busy}, 32'd1);
      check("done_run", {31'd0, bus.done}, 32'd0);
      check("S_held_run", {24'd0, bus.S}, {24'd0, held_s});
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_c9", {31'd0, bus.busy}, 32'd0);
    check("done_c9", {31'd0, bus.done}, 32'd1);
    held_s = es;
    @(posedge clk); #1;
    @(negedge clk);
    check("done_c10", {31'd0, bus.done}, 32'd0);
    check("busy_c10", {31'd0, bus.busy}, 32'd0);
    check("S_held_idle", {24'd0, bus.S}, {24'd0, es});
  endtask

  initial begin
    int done_snap;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = 8'd0;
    bus.B     = 8'd0;
    bus.Cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_S", {24'd0, bus.S}, 32'd0);
      check("rst_Cout", {31'd0, bus.Cout}, 32'd0);
      check("rst_V", {31'd0, bus.V}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
    end

    run_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    done_snap = n_done;
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    repeat (12) @(posedge clk);
    check("ignored_start_one_done", 32'(n_done - done_snap), 32'd1);

    // Reset in cycle 5 of a running addition: abandoned, no done pulse.
    done_snap = n_done;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.A     = 8'hAA;
    bus.B     = 8'h55;
    bus.Cin   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_S", {24'd0, bus.S}, 32'd0);
    check("midrst_Cout", {31'd0, bus.Cout}, 32'd0);
    check("midrst_V", {31'd0, bus.V}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    held_s = 8'h00;
    repeat (12) @(posedge clk);
    check("midrst_no_done", 32'(n_done - done_snap), 32'd0);

    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("total_done_pulses", 32'(n_done), 32'd6);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_add8.md
# serial_add8

Bit-serial 8-bit adder for the calculator datapath; it is the addition counterpart to the subtract path. It accepts two 8-bit operands and a carry-in on a start pulse. It then resolves one bit per clock, LSB first, through a single 1-bit full-adder cell and a carry flip-flop, and presents the sum, carry-out and signed overflow with a one-cycle done pulse. The block sits between the operand registers and the result mux and trades latency for minimal adder area.

## Interface
Parameters: none. Width is fixed at 8 bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request to begin an addition; sampled only in IDLE.
- A  in  8  operand A; captured on the accepted start.
- B  in  8  operand B; captured on the accepted start.
- Cin  in  1  carry-in; captured on the accepted start.
- S  out  8  sum; valid from the done cycle, held until the next accepted start.
- Cout  out  1  carry out of bit 7; valid and held like S.
- V  out  1  signed overflow (carry into bit 7 XOR carry out of bit 7); valid and held like S.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when S/Cout/V become valid.

## Operation
- States:
  - IDLE: no operation in progress; waits for start.
  - RUN: adds one bit per clock.
  - DONE: presents the result and pulses done.
- IDLE, start=1 at an edge:
  - load shift register a_sh<=A, b_sh<=B, carry<=Cin, bit counter cnt<=0;
  - go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - sum bit = a_sh[0]^b_sh[0]^carry;
  - carry <= (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0]));
  - sum bit shifts into the S shift register from the MSB side (s_sh <= {sum_bit, s_sh[7:1]});
  - a_sh and b_sh shift right;
  - cnt <= cnt+1.
- RUN, edge where cnt==6: record carry-in to bit 7, c7 <= carry-out of this bit-6 step.
- RUN, edge where cnt==7 (eighth bit):
  - S <= final s_sh;
  - Cout <= carry out of bit 7;
  - V <= c7 ^ carry out of bit 7;
  - go to DONE.
- DONE: done=1 for exactly this cycle; next edge unconditionally returns to IDLE.
- start is ignored in RUN and DONE. No queuing: a start held high through DONE is accepted in the following IDLE cycle.
- A/B/Cin changes after the accepted start do not affect the result in progress.
- Arithmetic is unsigned modulo 256 with carry-out. V gives the two's-complement interpretation. Result {Cout,S} always equals A+B+Cin.

## Timing
- Reset, at any edge with rst=1 and in any state including mid-RUN:
  - state<=IDLE; S=0, Cout=0, V=0, busy=0, done=0; cnt and internal shift registers cleared.
  - The operation in progress is abandoned; no done pulse is produced.
- rst has priority over start in the same cycle.
- Latency, with start high in cycle 0 and accepted at the end of cycle 0:
  - busy=1 in cycles 1–8;
  - done=1 and S/Cout/V valid in cycle 9;
  - IDLE in cycle 10.
- Throughput: one addition per 10 cycles, or back-to-back if start is held continuously.
- S/Cout/V change only at the RUN→DONE edge and at reset. They never show partial results.
- busy and done are never high together. Outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset then idle: rst=1 for 2 cycles, start=0 → S=0x00, Cout=0, V=0, busy=0, done=0 held indefinitely.
- Basic add with signed overflow:
  - stimulus: A=0x3C, B=0x5A, Cin=0, start pulse;
  - required: busy exactly cycles 1–8, done only in cycle 9;
  - result: S=0x96, Cout=0, V=1.
- Carry ripple through all bits: A=0xFF, B=0x01, Cin=0 → S=0x00, Cout=1, V=0.
- Carry-in and overflow:
  - A=0x7F, B=0x00, Cin=1 → S=0x80, Cout=0, V=1;
  - then A=0x80, B=0x80, Cin=0 → S=0x00, Cout=1, V=1.
- Ignored start and operand change:
  - stimulus: start A=0x12, B=0x34; pulse start with A=0xFF, B=0xFF in cycle 4, and change A/B every cycle during RUN;
  - required: exactly one done pulse, S=0x46, Cout=0, V=0.
- Reset mid-operation:
  - stimulus: start A=0xAA, B=0x55; assert rst in cycle 5;
  - required: no done pulse; outputs all 0 next cycle;
  - follow-up: a fresh start with A=0x01, B=0x02 gives S=0x03 after the full 9-cycle latency.
